// File: rtl/sid_envelope_if.sv
// Register-write bus for one SID voice envelope: write strobe, address and data.
// The CPU-side driver uses the master modport and the envelope uses the slave modport.
interface sid_envelope_if;
    logic       iWE;
    logic [4:0] iAddr;
    logic [7:0] iData;

    modport master (output iWE, output iAddr, output iData);
    modport slave  (input  iWE, input  iAddr, input  iData);
endinterface

// File: rtl/sid_envelope.sv
// SID ADSR envelope generator plus VCA for one voice. Define SID_ENV_EXP_EN for exponential
// decay/release stepping; without it decay/release step once per rate tick.
module sid_envelope #(
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          iRstN,
    input  logic          clkEn,
    sid_envelope_if.slave bus,
    input  logic [11:0]   iVoice,
    output logic [7:0]    oEnv,
    output logic [11:0]   oOut
);
    localparam logic [4:0] ADDR_CTRL = 5'(BASE_ADDR + 32'd4);
    localparam logic [4:0] ADDR_AD   = 5'(BASE_ADDR + 32'd5);
    localparam logic [4:0] ADDR_SR   = 5'(BASE_ADDR + 32'd6);

    typedef enum logic [1:0] {
        ST_ATTACK        = 2'd0,
        ST_DECAY_SUSTAIN = 2'd1,
        ST_RELEASE       = 2'd2
    } state_t;

    function automatic logic [14:0] rate_cmp(input logic [3:0] sel);
        logic [14:0] cmp;
        case (sel)
            4'd0:    cmp = 15'd8;
            4'd1:    cmp = 15'd31;
            4'd2:    cmp = 15'd62;
            4'd3:    cmp = 15'd94;
            4'd4:    cmp = 15'd148;
            4'd5:    cmp = 15'd219;
            4'd6:    cmp = 15'd266;
            4'd7:    cmp = 15'd312;
            4'd8:    cmp = 15'd391;
            4'd9:    cmp = 15'd976;
            4'd10:   cmp = 15'd1953;
            4'd11:   cmp = 15'd3125;
            4'd12:   cmp = 15'd3906;
            4'd13:   cmp = 15'd11719;
            4'd14:   cmp = 15'd19531;
            default: cmp = 15'd31250;
        endcase
        return cmp;
    endfunction

`ifdef SID_ENV_EXP_EN
    function automatic logic [4:0] exp_period(input logic [7:0] level);
        logic [4:0] per;
        if (level > 8'h5D) begin
            per = 5'd1;
        end else if (level >= 8'h37) begin
            per = 5'd2;
        end else if (level >= 8'h1B) begin
            per = 5'd4;
        end else if (level >= 8'h0F) begin
            per = 5'd8;
        end else if (level >= 8'h07) begin
            per = 5'd16;
        end else if (level >= 8'h01) begin
            per = 5'd30;
        end else begin
            per = 5'd1;
        end
        return per;
    endfunction
`endif

    logic        gate_r;
    logic        gate_seen_r;
    logic [3:0]  atk_r;
    logic [3:0]  dec_r;
    logic [3:0]  sus_r;
    logic [3:0]  rel_r;
    state_t      state_r;
    state_t      state_n;
    state_t      eff_state_s;
    logic [7:0]  env_r;
    logic [7:0]  env_n;
    logic [14:0] rate_cnt_r;
    logic [14:0] rate_cnt_n;
    logic [3:0]  rate_sel_s;
    logic        gate_rise_s;
    logic        gate_fall_s;
    logic        rate_tick_s;
    logic        fall_step_s;
    logic [11:0] out_r;
`ifdef SID_ENV_EXP_EN
    logic [4:0]  exp_cnt_r;
    logic [4:0]  exp_cnt_n;
`endif

    logic signed [11:0] voice_s;
    logic signed [19:0] prod_s;
    logic               unused_prod_s;

    // Voice register writes; these ignore clkEn.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            gate_r <= 1'b0;
            atk_r  <= 4'd0;
            dec_r  <= 4'd0;
            sus_r  <= 4'd0;
            rel_r  <= 4'd0;
        end else if (bus.iWE) begin
            case (bus.iAddr)
                ADDR_CTRL: gate_r <= bus.iData[0];
                ADDR_AD: begin
                    atk_r <= bus.iData[7:4];
                    dec_r <= bus.iData[3:0];
                end
                ADDR_SR: begin
                    sus_r <= bus.iData[7:4];
                    rel_r <= bus.iData[3:0];
                end
                default: begin
                    gate_r <= gate_r;
                end
            endcase
        end
    end

    // Gate edges override the current state before the rate tick is applied.
    always_comb begin
        gate_rise_s = clkEn & gate_r & ~gate_seen_r;
        gate_fall_s = clkEn & ~gate_r & gate_seen_r;
        if (gate_rise_s) begin
            eff_state_s = ST_ATTACK;
        end else if (gate_fall_s) begin
            eff_state_s = ST_RELEASE;
        end else begin
            eff_state_s = state_r;
        end
        case (eff_state_s)
            ST_ATTACK:        rate_sel_s = atk_r;
            ST_DECAY_SUSTAIN: rate_sel_s = dec_r;
            default:          rate_sel_s = rel_r;
        endcase
        rate_tick_s = clkEn & (rate_cnt_r == rate_cmp(rate_sel_s));
        fall_step_s = rate_tick_s &
                      (((eff_state_s == ST_DECAY_SUSTAIN) && (env_r > {sus_r, sus_r})) ||
                       ((eff_state_s == ST_RELEASE) && (env_r != 8'h00)));
    end

    // State register.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            state_r <= ST_RELEASE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state: attack hands over to decay on the step that reaches full scale.
    always_comb begin
        if (rate_tick_s && (eff_state_s == ST_ATTACK) && (env_r >= 8'hFE)) begin
            state_n = ST_DECAY_SUSTAIN;
        end else begin
            state_n = eff_state_s;
        end
    end

    // Envelope, rate counter and exponential divider next values.
    always_comb begin
        env_n = env_r;
`ifdef SID_ENV_EXP_EN
        exp_cnt_n = exp_cnt_r;
`endif
        if (!clkEn) begin
            rate_cnt_n = rate_cnt_r;
        end else if (rate_tick_s) begin
            rate_cnt_n = 15'd0;
        end else begin
            rate_cnt_n = rate_cnt_r + 15'd1;
        end
        if (rate_tick_s && (eff_state_s == ST_ATTACK)) begin
            if (env_r != 8'hFF) begin
                env_n = env_r + 8'd1;
            end else begin
                env_n = env_r;
            end
`ifdef SID_ENV_EXP_EN
            exp_cnt_n = 5'd0;
`endif
        end else if (fall_step_s) begin
`ifdef SID_ENV_EXP_EN
            if (exp_cnt_r == (exp_period(env_r) - 5'd1)) begin
                env_n     = env_r - 8'd1;
                exp_cnt_n = 5'd0;
            end else begin
                exp_cnt_n = exp_cnt_r + 5'd1;
            end
`else
            env_n = env_r - 8'd1;
`endif
        end else begin
            env_n = env_r;
        end
    end

    // Envelope datapath registers.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            env_r       <= 8'd0;
            rate_cnt_r  <= 15'd0;
            gate_seen_r <= 1'b0;
`ifdef SID_ENV_EXP_EN
            exp_cnt_r   <= 5'd0;
`endif
        end else begin
            env_r      <= env_n;
            rate_cnt_r <= rate_cnt_n;
            if (clkEn) begin
                gate_seen_r <= gate_r;
            end
`ifdef SID_ENV_EXP_EN
            exp_cnt_r  <= exp_cnt_n;
`endif
        end
    end

    // Offset-binary waveform becomes signed; the product always fits 20 signed bits.
    assign voice_s       = {~iVoice[11], iVoice[10:0]};
    assign prod_s        = voice_s * $signed({1'b0, env_r});
    assign unused_prod_s = ^prod_s[7:0];

    // VCA output register, updated every clock.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            out_r <= 12'd0;
        end else begin
            out_r <= prod_s[19:8];
        end
    end

    assign oEnv = env_r;
    assign oOut = out_r;

endmodule

// File: tb/tb_sid_envelope.sv
// Randomised scoreboard bench for sid_envelope: a behavioural ADSR/VCA model predicts every
// clock's oEnv/oOut, and a monitor compares them one clock later.
module tb_sid_envelope;
    logic        clk = 1'b0;
    logic        iRstN;
    logic        clkEn;
    logic [11:0] iVoice;
    logic [7:0]  oEnv;
    logic [11:0] oOut;

    sid_envelope_if bus ();

    sid_envelope #(.BASE_ADDR(0)) dut (
        .clk   (clk),
        .iRstN (iRstN),
        .clkEn (clkEn),
        .bus   (bus),
        .iVoice(iVoice),
        .oEnv  (oEnv),
        .oOut  (oOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  env;
        logic [11:0] out;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: phase 0=attack, 1=decay/sustain, 2=release.
    int m_env, m_phase, m_cnt, m_exp;
    int m_gate, m_prev, m_atk, m_dec, m_sus, m_rel;
    int rate_limit[16] = '{8, 31, 62, 94, 148, 219, 266, 312, 391, 976, 1953, 3125, 3906,
                           11719, 19531, 31250};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int period(input int level);
`ifdef SID_ENV_EXP_EN
        if (level >= 94) return 1;
        if (level >= 55) return 2;
        if (level >= 27) return 4;
        if (level >= 15) return 8;
        if (level >= 7)  return 16;
        if (level >= 1)  return 30;
        return 1;
`else
        return 1;
`endif
    endfunction

    function automatic logic [11:0] vca(input logic [11:0] v, input int level);
        int p;
        p = (int'(v) - 2048) * level;
        p = p >>> 8;
        return p[11:0];
    endfunction

    task automatic model_reset();
        m_env = 0; m_phase = 2; m_cnt = 0; m_exp = 0;
        m_gate = 0; m_prev = 0; m_atk = 0; m_dec = 0; m_sus = 0; m_rel = 0;
    endtask

    task automatic step_down();
        if (m_exp + 1 >= period(m_env)) begin
            m_env = m_env - 1;
            m_exp = 0;
        end else begin
            m_exp = m_exp + 1;
        end
    endtask

    // Drive one clock's inputs at a falling edge, predict the next rising edge, advance.
    task automatic cycle(input logic en, input logic we, input logic [4:0] addr,
                         input logic [7:0] data, input logic [11:0] voice);
        exp_t e;
        int   sel;
        clkEn     = en;
        bus.iWE   = we;
        bus.iAddr = addr;
        bus.iData = data;
        iVoice    = voice;
        e.out = vca(voice, m_env);
        if (en) begin
            if (m_gate == 1 && m_prev == 0) m_phase = 0;
            else if (m_gate == 0 && m_prev == 1) m_phase = 2;
            m_prev = m_gate;
            sel = (m_phase == 0) ? m_atk : (m_phase == 1) ? m_dec : m_rel;
            if (m_cnt == rate_limit[sel]) begin
                m_cnt = 0;
                if (m_phase == 0) begin
                    if (m_env < 255) m_env = m_env + 1;
                    m_exp = 0;
                    if (m_env == 255) m_phase = 1;
                end else if (m_phase == 1) begin
                    if (m_env > m_sus * 17) step_down();
                end else begin
                    if (m_env > 0) step_down();
                end
            end else begin
                m_cnt = (m_cnt + 1) % 32768;
            end
        end
        if (we) begin
            if (addr == 5'd4) m_gate = int'(data[0]);
            if (addr == 5'd5) begin m_atk = int'(data[7:4]); m_dec = int'(data[3:0]); end
            if (addr == 5'd6) begin m_sus = int'(data[7:4]); m_rel = int'(data[3:0]); end
        end
        e.env = 8'(m_env);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'd0, 8'd0, 12'($urandom));
    endtask

    task automatic do_reset();
        exp_t e;
        iRstN = 1'b0;
        #1;
        check("async_reset_env", 32'(oEnv), 32'd0);
        check("async_reset_out", 32'(oOut), 32'd0);
        model_reset();
        e.env = 8'd0;
        e.out = 12'd0;
        sb.push_back(e);
        @(negedge clk);
        iRstN = 1'b1;
    endtask

    // Monitor: outputs are compared just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_env", 32'(oEnv), 32'(e.env));
                check("sb_out", 32'(oOut), 32'(e.out));
            end
        end
    end

    initial begin
        int          n;
        logic [7:0]  lvl;
        logic [4:0]  a;
        logic [7:0]  d;
        iRstN = 1'b0; clkEn = 1'b0; iVoice = 12'd0;
        bus.iWE = 1'b0; bus.iAddr = 5'd0; bus.iData = 8'd0;
        model_reset();
        #12;
        check("reset_env", 32'(oEnv), 32'd0);
        check("reset_out", 32'(oOut), 32'd0);
        @(negedge clk);
        iRstN = 1'b1;

        // Fastest attack up to full scale, sustain at full scale.
        cycle(1'b1, 1'b1, 5'd5, 8'h00, 12'($urandom));
        cycle(1'b1, 1'b1, 5'd6, 8'hF0, 12'($urandom));
        cycle(1'b1, 1'b1, 5'd4, 8'h01, 12'($urandom));
        n = 0;
        while (oEnv !== 8'hFF && n < 3000) begin
            idle(1);
            n++;
        end
        check("attack_len_ok", 32'(n >= 2286 && n <= 2304), 32'd1);

        // VCA extremes at full envelope.
        cycle(1'b1, 1'b0, 5'd0, 8'd0, 12'hFFF);
        check("vca_max", 32'(oOut), 32'h7F7);
        cycle(1'b1, 1'b0, 5'd0, 8'd0, 12'h000);
        check("vca_min", 32'(oOut), 32'h808);
        cycle(1'b1, 1'b0, 5'd0, 8'd0, 12'h800);
        check("vca_mid", 32'(oOut), 32'h000);

        // Decay to sustain 'h88 and hold.
        cycle(1'b1, 1'b1, 5'd6, 8'h80, 12'($urandom));
        idle(3000);
        check("sustain_hold", 32'(oEnv), 32'h88);

        // Release with rel=0 to the floor and stay there.
        cycle(1'b1, 1'b1, 5'd4, 8'h00, 12'($urandom));
        idle(10000);
        check("release_floor", 32'(oEnv), 32'h00);

        // Lowering the release rate below the running count waits for the counter wrap.
        cycle(1'b1, 1'b1, 5'd4, 8'h01, 12'($urandom));
        idle(600);
        cycle(1'b1, 1'b1, 5'd6, 8'h8F, 12'($urandom));
        cycle(1'b1, 1'b1, 5'd4, 8'h00, 12'($urandom));
        idle(20000);
        lvl = oEnv;
        cycle(1'b1, 1'b1, 5'd6, 8'h80, 12'($urandom));
        n = 0;
        while (oEnv === lvl && n < 14000) begin
            idle(1);
            n++;
        end
        check("wrap_delay_ok", 32'(n >= 12700 && n <= 12800), 32'd1);
        idle(200);

        // Asynchronous reset in the middle of an attack.
        cycle(1'b1, 1'b1, 5'd5, 8'h00, 12'($urandom));
        cycle(1'b1, 1'b1, 5'd4, 8'h01, 12'($urandom));
        idle(300);
        do_reset();
        for (int i = 0; i < 500; i++)
            cycle(1'($urandom_range(0, 1)), 1'b0, 5'd0, 8'd0, 12'($urandom));
        check("post_reset_env", 32'(oEnv), 32'd0);

        // Random register traffic, gate toggles and sparse clkEn.
        for (int i = 0; i < 12000; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 5'd4;
                1:       a = 5'd5;
                2:       a = 5'd6;
                default: a = 5'($urandom);
            endcase
            d = 8'($urandom);
            if ((a != 5'd4) && ($urandom_range(0, 1) == 1)) d = d & 8'h33;
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), a, d,
                  12'($urandom));
        end

        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
